// File: rtl/core_types_pkg.sv
// rtl/core_types_pkg.sv - shared core sizing constants
package core_types_pkg;

    localparam int RAS_ENTRIES      = 8;
    localparam int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES);
    localparam int RAS_TARGET_WIDTH = 31;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - return address stack with circular overwrite and checkpoint restore
module ras_stack #(
    parameter int RAS_ENTRIES      = core_types_pkg::RAS_ENTRIES,
    parameter int RAS_INDEX_WIDTH  = core_types_pkg::RAS_INDEX_WIDTH,
    parameter int RAS_TARGET_WIDTH = core_types_pkg::RAS_TARGET_WIDTH
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        push_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] push_target,
    input  logic                        pop_valid,
    input  logic                        restore_valid,
    input  logic [RAS_INDEX_WIDTH-1:0]  restore_index,
    input  logic [RAS_INDEX_WIDTH:0]    restore_count,
    output logic [RAS_TARGET_WIDTH-1:0] top_target,
    output logic                        top_valid,
    output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
    output logic [RAS_INDEX_WIDTH:0]    ras_count
);

    localparam logic [RAS_INDEX_WIDTH:0] COUNT_FULL = RAS_ENTRIES[RAS_INDEX_WIDTH:0];

    logic [RAS_TARGET_WIDTH-1:0] entries [RAS_ENTRIES];
    logic [RAS_INDEX_WIDTH-1:0]  ptr;
    logic [RAS_INDEX_WIDTH:0]    cnt;
    logic [RAS_INDEX_WIDTH-1:0]  ptr_inc;
    logic [RAS_INDEX_WIDTH-1:0]  ptr_dec;
    logic                        empty;

    // Pointer arithmetic wraps naturally because the depth is a power of two.
    assign ptr_inc = ptr + 1'b1;
    assign ptr_dec = ptr - 1'b1;
    assign empty   = (cnt == '0);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr <= '0;
            cnt <= '0;
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                entries[i] <= '0;
            end
        end else if (restore_valid) begin
            ptr <= restore_index;
            cnt <= (restore_count > COUNT_FULL) ? COUNT_FULL : restore_count;
        end else if (push_valid && (!pop_valid || empty)) begin
            // A full stack silently overwrites its oldest slot; count saturates.
            ptr              <= ptr_inc;
            entries[ptr_inc] <= push_target;
            cnt              <= (cnt == COUNT_FULL) ? COUNT_FULL : cnt + 1'b1;
        end else if (push_valid && pop_valid) begin
            entries[ptr] <= push_target;
        end else if (pop_valid && !empty) begin
            ptr <= ptr_dec;
            cnt <= cnt - 1'b1;
        end
    end

    assign top_target = entries[ptr];
    assign top_valid  = !empty;
    assign ras_index  = ptr;
    assign ras_count  = cnt;

endmodule

// File: tb/tb_ras_stack.sv
// tb/tb_ras_stack.sv - directed self-checking bench for ras_stack
module tb_ras_stack;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        push_valid = 1'b0;
    logic [30:0] push_target = '0;
    logic        pop_valid = 1'b0;
    logic        restore_valid = 1'b0;
    logic [2:0]  restore_index = '0;
    logic [3:0]  restore_count = '0;
    logic [30:0] top_target;
    logic        top_valid;
    logic [2:0]  ras_index;
    logic [3:0]  ras_count;
    logic [38:0] st;
    logic [38:0] exp_st;

    int checks = 0;
    int errors = 0;

    ras_stack dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .push_valid   (push_valid),
        .push_target  (push_target),
        .pop_valid    (pop_valid),
        .restore_valid(restore_valid),
        .restore_index(restore_index),
        .restore_count(restore_count),
        .top_target   (top_target),
        .top_valid    (top_valid),
        .ras_index    (ras_index),
        .ras_count    (ras_count)
    );

    always #5 CLK = ~CLK;

    assign st = {ras_index, ras_count, top_valid, top_target};

    task automatic step(input logic p, input logic [30:0] t, input logic q);
        push_valid  = p;
        push_target = t;
        pop_valid   = q;
        @(posedge CLK);
        #1;
        push_valid  = 1'b0;
        pop_valid   = 1'b0;
        push_target = '0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (st !== 39'd0) begin
            errors++;
            $display("FAIL reset_state got %h exp %h", st, 39'd0);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        step(1'b1, 31'h100, 1'b0);
        step(1'b1, 31'h200, 1'b0);
        push_valid  = 1'b1;
        push_target = 31'h300;
        #2;
        exp_st = {3'd2, 4'd2, 1'b1, 31'h200};
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL no_bypass got %h exp %h", st, exp_st);
        end
        step(1'b1, 31'h300, 1'b0);
        exp_st = {3'd3, 4'd3, 1'b1, 31'h300};
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL push3 got %h exp %h", st, exp_st);
        end
        step(1'b0, '0, 1'b1);
        exp_st = {3'd2, 4'd2, 1'b1, 31'h200};
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL pop1 got %h exp %h", st, exp_st);
        end
        step(1'b0, '0, 1'b1);
        exp_st = {3'd1, 4'd1, 1'b1, 31'h100};
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL pop2 got %h exp %h", st, exp_st);
        end
        step(1'b0, '0, 1'b1);
        checks++;
        if (top_valid !== 1'b0 || ras_count !== 4'd0) begin
            errors++;
            $display("FAIL pop3_empty got valid %b count %0d exp valid 0 count 0", top_valid, ras_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 31'(i), 1'b0);
        end
        exp_st = {3'd1, 4'd8, 1'b1, 31'h9};
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL wrap_full got %h exp %h", st, exp_st);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (top_target !== 31'(9 - i)) begin
                errors++;
                $display("FAIL wrap_pop%0d got %h exp %h", i, top_target, 31'(9 - i));
            end
            step(1'b0, '0, 1'b1);
        end
        exp_st = {3'd1, 4'd0, 1'b0, 31'h9};
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL wrap_drained got %h exp %h", st, exp_st);
        end
        step(1'b0, '0, 1'b1);
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL underflow got %h exp %h", st, exp_st);
        end
    endtask

    task automatic test_replace();
        do_reset();
        step(1'b1, 31'hA, 1'b0);
        step(1'b1, 31'hB, 1'b1);
        exp_st = {3'd1, 4'd1, 1'b1, 31'hB};
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL replace_top got %h exp %h", st, exp_st);
        end
    endtask

    task automatic test_restore();
        do_reset();
        step(1'b1, 31'hA, 1'b0);
        step(1'b1, 31'hB, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b1, 31'hC, 1'b0);
        restore_valid = 1'b1;
        restore_index = 3'd2;
        restore_count = 4'd2;
        step(1'b1, 31'hD, 1'b0);
        restore_valid = 1'b0;
        // Push of 0xC landed in slot 1, so slot 2 still holds 0xB.
        exp_st = {3'd2, 4'd2, 1'b1, 31'hB};
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL restore got %h exp %h", st, exp_st);
        end
        step(1'b0, '0, 1'b1);
        exp_st = {3'd1, 4'd1, 1'b1, 31'hC};
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL restore_pop got %h exp %h", st, exp_st);
        end
        restore_valid = 1'b1;
        restore_index = 3'd5;
        restore_count = 4'd15;
        step(1'b0, '0, 1'b1);
        restore_valid = 1'b0;
        checks++;
        if (ras_count !== 4'd8 || ras_index !== 3'd5) begin
            errors++;
            $display("FAIL restore_clamp got idx %0d cnt %0d exp idx 5 cnt 8", ras_index, ras_count);
        end
    endtask

    task automatic test_empty_pushpop_and_async_reset();
        do_reset();
        step(1'b1, 31'h55, 1'b1);
        exp_st = {3'd1, 4'd1, 1'b1, 31'h55};
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL empty_pushpop got %h exp %h", st, exp_st);
        end
        @(negedge CLK);
        push_valid  = 1'b1;
        push_target = 31'h77;
        nRST = 1'b0;
        #1;
        checks++;
        if (st !== 39'd0) begin
            errors++;
            $display("FAIL async_reset got %h exp %h", st, 39'd0);
        end
        @(posedge CLK);
        #1;
        push_valid = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        checks++;
        if (st !== 39'd0) begin
            errors++;
            $display("FAIL reset_drops_push got %h exp %h", st, 39'd0);
        end
        step(1'b1, 31'h66, 1'b0);
        exp_st = {3'd1, 4'd1, 1'b1, 31'h66};
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL post_reset_push got %h exp %h", st, exp_st);
        end
    endtask

    task automatic test_idle();
        repeat (3) step(1'b0, '0, 1'b0);
        exp_st = {3'd1, 4'd1, 1'b1, 31'h66};
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL idle_hold got %h exp %h", st, exp_st);
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_wrap();
        test_replace();
        test_restore();
        test_empty_pushpop_and_async_reset();
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
